// File: rtl/segre_dcache_mmu_responder.sv
`default_nettype none
// ============================================================================
//  Module      : segre_dcache_mmu_responder
//  Description : MMU-side responder for D-cache misses and dirty writebacks.
//                Serialises writebacks and line fills onto a single-outstanding
//                memory port, returns fills with a one-cycle ready pulse and
//                owns the D-cache LRU ages.
//  Revision    : 1.0 - initial release
// ============================================================================
module segre_dcache_mmu_responder #(
  parameter int ADDR_W    = 32,
  parameter int LANE_W    = 128,
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] miss_addr_i,
  input  logic              cache_access_i,
  input  logic [IDX_W-1:0]  access_index_i,
  input  logic              writeback_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [LANE_W-1:0] wb_data_i,
  output logic              data_rdy_o,
  output logic [LANE_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [IDX_W-1:0]  lru_index_o,
  output logic              wb_full_o,
  output logic              mem_rd_req_o,
  output logic              mem_wr_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LANE_W-1:0] mem_wr_data_o,
  input  logic              mem_ack_i,
  input  logic [LANE_W-1:0] mem_rd_data_i
);

  // Byte-offset bits within one lane are cleared on every line address.
  localparam int                OFFSET_W   = $clog2(LANE_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WB      = 2'd1,
    FILL    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               wb_valid;
  logic [ADDR_W-1:0]  wb_addr;
  logic [LANE_W-1:0]  wb_data;
  logic [ADDR_W-1:0]  fill_addr;
  logic               latch_miss;
  logic [IDX_W-1:0]   age      [NUM_LANES];
  logic [IDX_W-1:0]   age_next [NUM_LANES];
  logic [IDX_W-1:0]   lru_idx;
  logic               touch_en;
  logic [IDX_W-1:0]   touch_idx;

  // Next-state logic; a pending writeback always drains before a refetch.
  always_comb begin
    state_next = state;
    latch_miss = 1'b0;
    case (state)
      IDLE: begin
        if (wb_valid || writeback_i) begin
          state_next = WB;
        end else if (miss_i) begin
          state_next = FILL;
          latch_miss = 1'b1;
        end
      end
      WB: begin
        if (mem_ack_i) begin
          if (miss_i) begin
            state_next = FILL;
            latch_miss = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      FILL: begin
        if (mem_ack_i) state_next = RESPOND;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Single-entry writeback buffer; a pulse while occupied is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (!wb_valid && writeback_i) begin
      wb_valid <= 1'b1;
      wb_addr  <= wb_addr_i & ALIGN_MASK;
      wb_data  <= wb_data_i;
    end else if (state == WB && mem_ack_i) begin
      wb_valid <= 1'b0;
    end
  end

  // Miss address latch and fill result registers (held until next fill).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_addr <= '0;
      data_o    <= '0;
      addr_o    <= '0;
    end else begin
      if (latch_miss) fill_addr <= miss_addr_i & ALIGN_MASK;
      if (state == FILL && mem_ack_i) begin
        data_o <= mem_rd_data_i;
        addr_o <= fill_addr;
      end
    end
  end

  // Memory port and handshake outputs, decoded from the registered state.
  always_comb begin
    mem_rd_req_o  = (state == FILL);
    mem_wr_req_o  = (state == WB);
    data_rdy_o    = (state == RESPOND);
    wb_full_o     = wb_valid;
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    if (state == WB) begin
      mem_addr_o    = wb_addr;
      mem_wr_data_o = wb_data;
    end else if (state == FILL) begin
      mem_addr_o = fill_addr;
    end
  end

  // Victim is the lane whose age is the oldest value.
  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (age[i] == IDX_W'(NUM_LANES - 1)) lru_idx = IDX_W'(i);
    end
  end
  assign lru_index_o = lru_idx;

  // Touch source select: the fill touch overrides a coincident hit.
  always_comb begin
    touch_en  = 1'b0;
    touch_idx = '0;
    if (state == RESPOND) begin
      touch_en  = 1'b1;
      touch_idx = lru_idx;
    end else if (cache_access_i) begin
      touch_en  = 1'b1;
      touch_idx = access_index_i;
    end
  end

  // Touch update: younger lanes age by one, touched lane becomes MRU.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      age_next[i] = age[i];
      if (touch_en) begin
        if (IDX_W'(i) == touch_idx)       age_next[i] = '0;
        else if (age[i] < age[touch_idx]) age_next[i] = age[i] + IDX_W'(1);
      end
    end
  end

  // Age registers; reset order makes the highest lane the first victim.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_LANES; i++) age[i] <= IDX_W'(i);
    end else begin
      for (int i = 0; i < NUM_LANES; i++) age[i] <= age_next[i];
    end
  end

endmodule
`default_nettype wire

// File: doc/segre_dcache_mmu_responder.md
Name: segre_dcache_mmu_responder

Overview:
- MMU-side responder for the data-cache miss/writeback interface driven by the memory pipeline.
- Accepts line misses and dirty-victim writebacks, and serialises them onto a single-outstanding memory port.
- Returns the filled lane with a one-cycle ready pulse and supplies the LRU victim index.
- Owns the D-cache LRU state, updated on cache hits and on fills.

Parameters:
ADDR_W, 32, address width
LANE_W, 128, cache lane width in bits
NUM_LANES, 4, D-cache lanes tracked for LRU
IDX_W, 2, log2(NUM_LANES)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
miss_i  in  1  line miss request; level, held until data_rdy_o
miss_addr_i  in  ADDR_W  miss address (any byte in line)
cache_access_i  in  1  hit access this cycle
access_index_i  in  IDX_W  lane hit by cache_access_i
writeback_i  in  1  one-cycle pulse: evicted dirty lane
wb_addr_i  in  ADDR_W  evicted lane address
wb_data_i  in  LANE_W  evicted lane data
data_rdy_o  out  1  one-cycle fill-complete pulse
data_o  out  LANE_W  fill data, valid with data_rdy_o
addr_o  out  ADDR_W  line-aligned fill address, valid with data_rdy_o
lru_index_o  out  IDX_W  lane to replace on fill
wb_full_o  out  1  writeback buffer occupied
mem_rd_req_o  out  1  memory line read request
mem_wr_req_o  out  1  memory line write request
mem_addr_o  out  ADDR_W  line-aligned memory address
mem_wr_data_o  out  LANE_W  write data
mem_ack_i  in  1  memory completes current request this cycle
mem_rd_data_i  in  LANE_W  read data, valid with mem_ack_i

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State returns to IDLE.
  - data_rdy_o, data_o, addr_o, mem_* outputs, and wb_full_o are all 0.
  - Writeback buffer is invalidated.
  - LRU ages reset to age[i]=i, so lru_index_o = NUM_LANES-1.
  - Reset during any state aborts the operation; no data_rdy_o is produced for it.
- Line alignment: the low log2(LANE_W/8) address bits are forced to 0 on mem_addr_o and addr_o.
- Writeback buffer, 1 entry:
  - writeback_i with buffer empty latches wb_addr_i and wb_data_i; wb_full_o=1 from the next cycle.
  - Requester must not pulse writeback_i while wb_full_o=1. The responder ignores such a pulse, and the bench flags it.
- FSM states: IDLE, WB, FILL, RESPOND.
  - IDLE -> WB if the buffer is valid, or if writeback_i is high this cycle. WB has priority over a pending miss, so memory is coherent before any refetch.
  - IDLE -> FILL if miss_i is high and the buffer is empty with no writeback_i this cycle. Latch the aligned miss address.
  - WB: mem_wr_req_o=1, mem_addr_o=buffer address, mem_wr_data_o=buffer data.
    - Held until mem_ack_i.
    - On ack: buffer invalidated (wb_full_o=0 next cycle).
    - Next state is FILL if miss_i is high (miss address latched at that edge), else IDLE.
  - FILL: mem_rd_req_o=1, mem_addr_o=latched address.
    - Held until mem_ack_i.
    - On ack: capture mem_rd_data_i into data_o, then go to RESPOND.
  - RESPOND: data_rdy_o=1 for exactly one cycle, with addr_o = latched address. Then go to IDLE.
- Requester handshake: miss_i deasserts no earlier than the cycle after data_rdy_o; IDLE does not sample miss_i in the RESPOND cycle.
- Memory protocol:
  - mem_ack_i is sampled only while a request is high.
  - Ack is allowed in the first request cycle.
  - mem_rd_req_o and mem_wr_req_o are never both high.
- Minimum latency:
  - Miss seen in IDLE at cycle 0 -> FILL at cycle 1 -> ack at cycle 1 -> data_rdy_o at cycle 2.
  - Each WB adds at least one cycle.
- LRU:
  - Per-lane IDX_W-bit age; 0 = MRU, NUM_LANES-1 = LRU.
  - Ages always form a permutation.
  - lru_index_o is the lane with age NUM_LANES-1, combinational from registered ages.
  - touch(k): every lane with age < age[k] increments, and age[k] becomes 0.
  - cache_access_i touches access_index_i.
  - The RESPOND cycle touches the current lru_index_o, i.e. the filled lane. If cache_access_i coincides with RESPOND, the fill touch wins and the access is dropped.
  - touch of a lane that is already MRU leaves all ages unchanged.
- Data outputs: data_o and addr_o hold their value until the next fill.

Test Plan:
- Reset (asynchronous pulse, no clock edge) -> all outputs 0 and lru_index_o=3 immediately.
- miss_i=1, miss_addr_i=0x0000_1234; ack 3 cycles after mem_rd_req_o with data 0xDEADBEEF_CAFEF00D_01234567_89ABCDEF:
  - mem_addr_o=0x0000_1230.
  - One-cycle data_rdy_o with data_o equal to that value and addr_o=0x0000_1230.
  - lru_index_o=3 during the pulse, 2 the next cycle.
- writeback_i with wb_addr_i=0x2000, data A, then miss_i at 0x2004 in the same cycle:
  - mem_wr_req_o first at 0x2000 with data A.
  - Then mem_rd_req_o at 0x2000.
  - wb_full_o is high from the cycle after capture until after the write ack.
- Accesses to lanes 0,1,2,3 on consecutive cycles -> lru_index_o=0; then access lane 0 -> lru_index_o=1; access to the MRU lane -> no change.
- Miss with mem_ack_i already high -> data_rdy_o exactly 2 cycles after miss_i first seen in IDLE.
- rst_i asserted mid-FILL -> mem_rd_req_o drops asynchronously, no data_rdy_o follows, and FSM is in IDLE after release.
